// File: rtl/aes_pkg.sv
// Shared AES definitions for the forward and inverse SubBytes paths:
// state/byte widths, the SubBytes engine FSM states and the inverse S-box table.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } subbytes_state_e;

    // Element 0 is the substitute for byte 0x00; rows of 16 follow the usual table layout.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_subbytes_serial_if.sv
// Valid/ready handshake bundle between InvShiftRows, the inverse SubBytes engine and AddRoundKey.
interface inv_subbytes_serial_if;
    import aes_pkg::*;

    logic                   i_valid;
    logic                   i_ready;
    logic [AES_STATE_W-1:0] state;
    logic                   o_valid;
    logic                   o_ready;
    logic [AES_STATE_W-1:0] state_out;

    modport slave (
        input  i_valid, state, o_ready,
        output i_ready, o_valid, state_out
    );

    modport master (
        output i_valid, state, o_ready,
        input  i_ready, o_valid, state_out
    );
endinterface

// File: rtl/inv_sbox_lookup.sv
// One combinational inverse S-box lane: a single byte in, its substitute out.
module inv_sbox_lookup
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] byte_i,
    output logic [AES_BYTE_W-1:0] byte_o
);

    assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/inv_subbytes_serial.sv
// Serial inverse SubBytes engine, BYTES_PER_CYCLE S-box lanes shared across the 16-byte state.
// Optional macro INV_SUBBYTES_PIPE_EN registers the lane outputs before the working-register write.
module inv_subbytes_serial
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_subbytes_serial_if.slave bus
);

    localparam int NUM_STEPS = (AES_STATE_W / AES_BYTE_W) / BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int LANE_W    = BYTES_PER_CYCLE * AES_BYTE_W;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("inv_subbytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    subbytes_state_e        state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_STATE_W-1:0] work_q;
    logic [AES_STATE_W-1:0] work_d;
    logic [AES_STATE_W-1:0] state_out_q;
    logic                   o_valid_q;
    logic                   i_ready_q;

    logic [LANE_W-1:0]      laneIn;
    logic [LANE_W-1:0]      laneOut;
    logic [LANE_W-1:0]      writeLanes;
    logic [CNT_W-1:0]       writeStep;

`ifdef INV_SUBBYTES_PIPE_EN
    logic [LANE_W-1:0]      pipe_q;
    logic [CNT_W-1:0]       pipeStep_q;
    logic                   pipeVld_q;
    logic                   issueDone_q;

    assign writeLanes = pipe_q;
    assign writeStep  = pipeStep_q;
`else
    assign writeLanes = laneOut;
    assign writeStep  = cnt_q;
`endif

    // Lane 0 carries the lowest-numbered byte of the group, i.e. the most significant slice.
    always_comb begin
        laneIn = '0;
        for (int s = 0; s < NUM_STEPS; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                laneIn = work_q[AES_STATE_W-1 - s*LANE_W -: LANE_W];
            end
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        inv_sbox_lookup u_lookup (
            .byte_i (laneIn [LANE_W-1 - g*AES_BYTE_W -: AES_BYTE_W]),
            .byte_o (laneOut[LANE_W-1 - g*AES_BYTE_W -: AES_BYTE_W])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int s = 0; s < NUM_STEPS; s++) begin
            if (writeStep == CNT_W'(s)) begin
                work_d[AES_STATE_W-1 - s*LANE_W -: LANE_W] = writeLanes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            state_out_q <= '0;
            o_valid_q   <= 1'b0;
            i_ready_q   <= 1'b1;
`ifdef INV_SUBBYTES_PIPE_EN
            pipe_q      <= '0;
            pipeStep_q  <= '0;
            pipeVld_q   <= 1'b0;
            issueDone_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && i_ready_q) begin
                        work_q    <= bus.state;
                        cnt_q     <= '0;
                        i_ready_q <= 1'b0;
                        state_q   <= BUSY;
`ifdef INV_SUBBYTES_PIPE_EN
                        pipeVld_q   <= 1'b0;
                        issueDone_q <= 1'b0;
`endif
                    end
                end
                BUSY: begin
`ifdef INV_SUBBYTES_PIPE_EN
                    // Issue side runs one step ahead of the write side.
                    if (!issueDone_q) begin
                        pipe_q     <= laneOut;
                        pipeStep_q <= cnt_q;
                        pipeVld_q  <= 1'b1;
                        if (cnt_q == LAST_STEP) begin
                            issueDone_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    if (pipeVld_q) begin
                        work_q <= work_d;
                        if (pipeStep_q == LAST_STEP) begin
                            state_out_q <= work_d;
                            o_valid_q   <= 1'b1;
                            pipeVld_q   <= 1'b0;
                            state_q     <= DONE;
                        end
                    end
`else
                    work_q <= work_d;
                    if (cnt_q == LAST_STEP) begin
                        state_out_q <= work_d;
                        o_valid_q   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    if (bus.o_ready) begin
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ready   = i_ready_q;
    assign bus.o_valid   = o_valid_q;
    assign bus.state_out = state_out_q;

endmodule

// File: tb/tb_inv_subbytes_serial.sv
// Directed self-checking bench for inv_subbytes_serial; one instance per legal lane count,
// with the detailed handshake sequence run against the 4-lane instance.
module tb_inv_subbytes_serial;

`ifdef INV_SUBBYTES_PIPE_EN
    localparam int PIPE_X = 1;
`else
    localparam int PIPE_X = 0;
`endif

    localparam logic [127:0] FIPS_IN  = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] FIPS_OUT = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] ALL_63   = {16{8'h63}};
    localparam logic [127:0] ALL_16   = {16{8'h16}};
    localparam logic [127:0] ALL_FF   = {16{8'hff}};
    localparam logic [127:0] ALL_52   = {16{8'h52}};
    localparam int LAT4 = 4 + PIPE_X;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iValid;
    logic         oReady;
    logic [127:0] stateIn;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    inv_subbytes_serial_if ifc1 ();
    inv_subbytes_serial_if ifc2 ();
    inv_subbytes_serial_if ifc4 ();
    inv_subbytes_serial_if ifc8 ();
    inv_subbytes_serial_if ifc16 ();

    assign ifc1.i_valid  = iValid;  assign ifc1.state  = stateIn;  assign ifc1.o_ready  = oReady;
    assign ifc2.i_valid  = iValid;  assign ifc2.state  = stateIn;  assign ifc2.o_ready  = oReady;
    assign ifc4.i_valid  = iValid;  assign ifc4.state  = stateIn;  assign ifc4.o_ready  = oReady;
    assign ifc8.i_valid  = iValid;  assign ifc8.state  = stateIn;  assign ifc8.o_ready  = oReady;
    assign ifc16.i_valid = iValid;  assign ifc16.state = stateIn;  assign ifc16.o_ready = oReady;

    inv_subbytes_serial #(.BYTES_PER_CYCLE(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    inv_subbytes_serial #(.BYTES_PER_CYCLE(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(ifc2));
    inv_subbytes_serial #(.BYTES_PER_CYCLE(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(ifc4));
    inv_subbytes_serial #(.BYTES_PER_CYCLE(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(ifc8));
    inv_subbytes_serial #(.BYTES_PER_CYCLE(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(ifc16));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [127:0] data);
        iValid  = valid;
        stateIn = data;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Accept one state on the 4-lane instance, wait for the result, check it and release it.
    task automatic runVector(input string tag, input logic [127:0] din, input logic [127:0] dout);
        int lat;
        lat = -1;
        applyStimulus(1'b1, din);
        tick;
        applyStimulus(1'b0, ~din);
        checkOutput({tag, " i_ready while busy"}, 128'(ifc4.i_ready), 128'(1'b0));
        for (int e = 1; e <= 24 && lat < 0; e++) begin
            tick;
            if (ifc4.o_valid) lat = e;
        end
        checkOutput({tag, " latency"}, 128'(lat), 128'(LAT4));
        checkOutput({tag, " data"}, ifc4.state_out, dout);
        oReady = 1'b1;
        tick;
        oReady = 1'b0;
        checkOutput({tag, " o_valid after release"}, 128'(ifc4.o_valid), 128'(1'b0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat1, lat2, lat4, lat8, lat16;
        int acc1, acc2, hs1, hs2;
        logic [127:0] out1, out2;
        logic preReady, preValid, preIValid;
        logic [127:0] preOut;

        rst_n  = 1'b0;
        oReady = 1'b0;
        applyStimulus(1'b0, '0);
        tick;
        tick;
        rst_n = 1'b1;
        $display("[TB] reset released");
        checkOutput("reset i_ready", 128'(ifc4.i_ready), 128'(1'b1));
        checkOutput("reset o_valid", 128'(ifc4.o_valid), 128'(1'b0));
        checkOutput("reset state_out", ifc4.state_out, '0);

        // FIPS vector on every lane count at once, measuring latency per instance
        lat1 = -1; lat2 = -1; lat4 = -1; lat8 = -1; lat16 = -1;
        applyStimulus(1'b1, FIPS_IN);
        tick;
        applyStimulus(1'b0, '0);
        for (int e = 1; e <= 24; e++) begin
            tick;
            if (ifc1.o_valid  && lat1  < 0) lat1  = e;
            if (ifc2.o_valid  && lat2  < 0) lat2  = e;
            if (ifc4.o_valid  && lat4  < 0) lat4  = e;
            if (ifc8.o_valid  && lat8  < 0) lat8  = e;
            if (ifc16.o_valid && lat16 < 0) lat16 = e;
        end
        checkOutput("bpc1 latency",  128'(lat1),  128'(16 + PIPE_X));
        checkOutput("bpc2 latency",  128'(lat2),  128'(8 + PIPE_X));
        checkOutput("bpc4 latency",  128'(lat4),  128'(4 + PIPE_X));
        checkOutput("bpc8 latency",  128'(lat8),  128'(2 + PIPE_X));
        checkOutput("bpc16 latency", 128'(lat16), 128'(1 + PIPE_X));
        checkOutput("bpc1 data",  ifc1.state_out,  FIPS_OUT);
        checkOutput("bpc2 data",  ifc2.state_out,  FIPS_OUT);
        checkOutput("bpc4 data",  ifc4.state_out,  FIPS_OUT);
        checkOutput("bpc8 data",  ifc8.state_out,  FIPS_OUT);
        checkOutput("bpc16 data", ifc16.state_out, FIPS_OUT);
        oReady = 1'b1;
        tick;
        oReady = 1'b0;
        checkOutput("release o_valid", 128'(ifc4.o_valid), 128'(1'b0));
        checkOutput("release i_ready", 128'(ifc4.i_ready), 128'(1'b1));

        runVector("all63", ALL_63, '0);
        runVector("all16", ALL_16, ALL_FF);
        runVector("all00", '0, ALL_52);

        // Backpressure: result must hold while inputs wiggle
        $display("[TB] backpressure");
        lat4 = -1;
        applyStimulus(1'b1, FIPS_IN);
        tick;
        applyStimulus(1'b0, '0);
        for (int e = 1; e <= 24 && lat4 < 0; e++) begin
            tick;
            if (ifc4.o_valid) lat4 = e;
        end
        checkOutput("bp latency", 128'(lat4), 128'(LAT4));
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c[0], {$urandom, $urandom, $urandom, $urandom});
            tick;
            checkOutput("bp o_valid", 128'(ifc4.o_valid), 128'(1'b1));
            checkOutput("bp state_out", ifc4.state_out, FIPS_OUT);
            checkOutput("bp i_ready", 128'(ifc4.i_ready), 128'(1'b0));
        end
        applyStimulus(1'b1, ALL_16);
        oReady = 1'b1;
        tick;
        oReady = 1'b0;
        applyStimulus(1'b0, '0);
        checkOutput("bp release o_valid", 128'(ifc4.o_valid), 128'(1'b0));
        checkOutput("bp release i_ready", 128'(ifc4.i_ready), 128'(1'b1));
        tick;
        checkOutput("bp no accept on release", 128'(ifc4.i_ready), 128'(1'b1));

        // Reset two steps into an operation
        $display("[TB] reset mid-busy");
        applyStimulus(1'b1, ALL_16);
        tick;
        applyStimulus(1'b0, '0);
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checkOutput("rst o_valid", 128'(ifc4.o_valid), 128'(1'b0));
        checkOutput("rst state_out", ifc4.state_out, '0);
        checkOutput("rst i_ready", 128'(ifc4.i_ready), 128'(1'b1));
        for (int c = 0; c < 6; c++) tick;
        checkOutput("rst no late o_valid", 128'(ifc4.o_valid), 128'(1'b0));
        runVector("post-reset all63", ALL_63, '0);

        // Back-to-back with i_valid held and o_ready tied high
        $display("[TB] back-to-back");
        acc1 = -1; acc2 = -1; hs1 = -1; hs2 = -1;
        out1 = '0; out2 = '0;
        oReady = 1'b1;
        applyStimulus(1'b1, FIPS_IN);
        for (int e = 1; e <= 40 && hs2 < 0; e++) begin
            preReady  = ifc4.i_ready;
            preValid  = ifc4.o_valid;
            preOut    = ifc4.state_out;
            preIValid = iValid;
            tick;
            if (preValid && oReady) begin
                if (hs1 < 0) begin
                    hs1 = e; out1 = preOut;
                end else if (hs2 < 0) begin
                    hs2 = e; out2 = preOut;
                end
            end
            if (preReady && preIValid) begin
                if (acc1 < 0) begin
                    acc1 = e;
                    applyStimulus(1'b1, '0);
                end else if (acc2 < 0) begin
                    acc2 = e;
                    applyStimulus(1'b0, '0);
                end
            end
        end
        oReady = 1'b0;
        checkOutput("b2b first result", out1, FIPS_OUT);
        checkOutput("b2b second result", out2, ALL_52);
        checkOutput("b2b first handshake gap", 128'(hs1 - acc1), 128'(LAT4 + 1));
        checkOutput("b2b second accept gap", 128'(acc2 - hs1), 128'(1));
        checkOutput("b2b second handshake gap", 128'(hs2 - acc2), 128'(LAT4 + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
